// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding, default wait bound and EX/MEM control-field layout.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   localparam int TIMEOUT_DEFAULT = 15;

   localparam int MEMREAD_BIT  = 2;
   localparam int MEMWRITE_BIT = 3;

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter: counts enabled cycles and flags the TIMEOUT-th one.
module mem_wait_timer
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   // Saturates at LAST so a held enable cannot wrap into a false second expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: request/ready handshake with a variable-latency data
// memory, pipeline stall generation, load capture and a bounded wait timer.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ValidM,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [ADDR_WIDTH-1:0] AddressM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  StallM,
   output logic [DATA_WIDTH-1:0] ReadDataW,
   output logic                  LoadValidW,
   output logic                  timeout_err
);

   state_t state, next_state;

   logic [MEMWRITE_BIT:0] ex_mem_ctrl;
   logic                  access;
   logic                  timer_clear;
   logic                  timer_en;
   logic                  timer_expired;

   // Rebuild the memory slice of the EX/MEM control word so bit positions match the pipeline register.
   always_comb begin
      ex_mem_ctrl               = '0;
      ex_mem_ctrl[MEMREAD_BIT]  = MemRead;
      ex_mem_ctrl[MEMWRITE_BIT] = MemWrite;
   end

   assign access = ValidM & (|ex_mem_ctrl);

   assign timer_clear = (state == IDLE);
   assign timer_en    = (state == ACCESS);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (access) next_state = ACCESS;
         ACCESS:  if (mem_ready || timer_expired) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Reset masks the stall at once so a held instruction does not keep the pipeline frozen.
   assign StallM = ~reset & (((state == IDLE) & access) | (state == ACCESS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         ReadDataW   <= '0;
         LoadValidW  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         LoadValidW <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  mem_req   <= 1'b1;
                  mem_we    <= ex_mem_ctrl[MEMWRITE_BIT];
                  mem_addr  <= AddressM;
                  mem_wdata <= WriteDataM;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     ReadDataW  <= mem_rdata;
                     LoadValidW <= 1'b1;
                  end
               end else if (timer_expired) begin
                  // An aborted load still retires, with zero data, so WB never waits forever.
                  mem_req     <= 1'b0;
                  timeout_err <= 1'b1;
                  if (!mem_we) begin
                     ReadDataW  <= '0;
                     LoadValidW <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load/store handshakes, timeout abort,
// back-to-back accesses, illegal encodings and asynchronous reset.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        ValidM;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] AddressM;
   logic [31:0] WriteDataM;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        StallM;
   logic [31:0] ReadDataW;
   logic        LoadValidW;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   mem_access_ctrl #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .TIMEOUT    (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ValidM      (ValidM),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .AddressM    (AddressM),
      .WriteDataM  (WriteDataM),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .StallM      (StallM),
      .ReadDataW   (ReadDataW),
      .LoadValidW  (LoadValidW),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
      ValidM     = v;
      MemRead    = rd;
      MemWrite   = wr;
      AddressM   = addr;
      WriteDataM = wd;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", StallM); end
      checks++; if (ReadDataW !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", ReadDataW); end
      checks++; if (LoadValidW !== 1'b0) begin failures++; $display("FAIL reset_lvalid: got %b expected 0", LoadValidW); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
   endtask

   task automatic test_load_zero_wait();
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hAAAA5555);
      mem_ready = 1'b0;
      #1;
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL ld0_c0_stall: got %b expected 1", StallM); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld0_c0_req: got %b expected 0", mem_req); end
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ld0_c1_req: got %b expected 1", mem_req); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ld0_c1_we: got %b expected 0", mem_we); end
      checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL ld0_c1_addr: got %h expected 10", mem_addr); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL ld0_c1_stall: got %b expected 1", StallM); end
      next_cycle();
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld0_c2_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL ld0_c2_stall: got %b expected 0", StallM); end
      checks++; if (LoadValidW !== 1'b1) begin failures++; $display("FAIL ld0_c2_lvalid: got %b expected 1", LoadValidW); end
      checks++; if (ReadDataW !== 32'hDEADBEEF) begin failures++; $display("FAIL ld0_c2_rdata: got %h expected deadbeef", ReadDataW); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checks++; if (LoadValidW !== 1'b0) begin failures++; $display("FAIL ld0_c3_lvalid: got %b expected 0", LoadValidW); end
      checks++; if (ReadDataW !== 32'hDEADBEEF) begin failures++; $display("FAIL ld0_c3_hold: got %h expected deadbeef", ReadDataW); end
   endtask

   task automatic test_store_wait();
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678);
      #1;
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL st_c0_stall: got %b expected 1", StallM); end
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         AddressM   = 32'h99;
         WriteDataM = 32'h0;
         mem_ready  = (k == 3);
         #1;
         checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL st_c%0d_req: got %b expected 1", k, mem_req); end
         checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL st_c%0d_we: got %b expected 1", k, mem_we); end
         checks++; if (mem_addr !== 32'h20) begin failures++; $display("FAIL st_c%0d_addr: got %h expected 20", k, mem_addr); end
         checks++; if (mem_wdata !== 32'h12345678) begin failures++; $display("FAIL st_c%0d_wdata: got %h expected 12345678", k, mem_wdata); end
         checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL st_c%0d_stall: got %b expected 1", k, StallM); end
      end
      next_cycle();
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL st_c4_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL st_c4_stall: got %b expected 0", StallM); end
      checks++; if (LoadValidW !== 1'b0) begin failures++; $display("FAIL st_c4_lvalid: got %b expected 0", LoadValidW); end
      checks++; if (ReadDataW !== 32'hDEADBEEF) begin failures++; $display("FAIL st_c4_rdata: got %h expected deadbeef", ReadDataW); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_timeout();
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
      mem_ready = 1'b0;
      #1;
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL to_c0_stall: got %b expected 1", StallM); end
      for (int k = 1; k <= 15; k++) begin
         next_cycle();
         #1;
         checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL to_c%0d_req: got %b expected 1", k, mem_req); end
         checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_c%0d_terr: got %b expected 0", k, timeout_err); end
      end
      next_cycle();
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL to_c16_req: got %b expected 0", mem_req); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_c16_terr: got %b expected 1", timeout_err); end
      checks++; if (LoadValidW !== 1'b1) begin failures++; $display("FAIL to_c16_lvalid: got %b expected 1", LoadValidW); end
      checks++; if (ReadDataW !== 32'h0) begin failures++; $display("FAIL to_c16_rdata: got %h expected 0", ReadDataW); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL to_c16_stall: got %b expected 0", StallM); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      next_cycle();
      mem_ready = 1'b0;
      #1;
      checks++; if (ReadDataW !== 32'hCAFEF00D) begin failures++; $display("FAIL to_clean_rdata: got %h expected cafef00d", ReadDataW); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h11111111;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_c0_req: got %b expected 0", mem_req); end
      next_cycle();
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL b2b_c1_req: got %b expected 1", mem_req); end
      next_cycle();
      mem_rdata = 32'h99999999;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_c2_req: got %b expected 0", mem_req); end
      checks++; if (ReadDataW !== 32'h11111111) begin failures++; $display("FAIL b2b_c2_rdata: got %h expected 11111111", ReadDataW); end
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 32'h60, 32'h22222222);
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_c3_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL b2b_c3_stall: got %b expected 1", StallM); end
      next_cycle();
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL b2b_c4_req: got %b expected 1", mem_req); end
      checks++; if (mem_addr !== 32'h60) begin failures++; $display("FAIL b2b_c4_addr: got %h expected 60", mem_addr); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL b2b_c4_we: got %b expected 1", mem_we); end
      next_cycle();
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_c5_req: got %b expected 0", mem_req); end
      checks++; if (LoadValidW !== 1'b0) begin failures++; $display("FAIL b2b_c5_lvalid: got %b expected 0", LoadValidW); end
      checks++; if (ReadDataW !== 32'h11111111) begin failures++; $display("FAIL b2b_c5_rdata: got %h expected 11111111", ReadDataW); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_ready = 1'b0;
   endtask

   task automatic test_illegal();
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 32'h70, 32'h33333333);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'h44444444;
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ill_c1_req: got %b expected 1", mem_req); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ill_c1_we: got %b expected 1", mem_we); end
      next_cycle();
      mem_ready = 1'b0;
      #1;
      checks++; if (LoadValidW !== 1'b0) begin failures++; $display("FAIL ill_c2_lvalid: got %b expected 0", LoadValidW); end
      checks++; if (ReadDataW !== 32'h11111111) begin failures++; $display("FAIL ill_c2_rdata: got %h expected 11111111", ReadDataW); end
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
      #1;
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL nomem_stall: got %b expected 0", StallM); end
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL nomem_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL nomem_alu_stall: got %b expected 0", StallM); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid_access();
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h90, 32'h0);
      mem_ready = 1'b0;
      next_cycle();
      next_cycle();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req: got %b expected 1", mem_req); end
      reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", mem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", StallM); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
      checks++; if (ReadDataW !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", ReadDataW); end
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_idle%0d_req: got %b expected 0", k, mem_req); end
         checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_idle%0d_stall: got %b expected 0", k, StallM); end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      test_load_zero_wait();
      test_store_wait();
      test_timeout();
      test_back_to_back();
      test_illegal();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
